// File: rtl/matx_job_sched_pkg.sv
// Shared types and widths for the matrix-vector job scheduler and its arbiter.
// Operands are 4x4 matrices and 4-vectors of 4-bit elements; results are 8-bit elements.
package matx_job_sched_pkg;

  localparam int N_REQ      = 2;
  localparam int VEC_LEN    = 4;
  localparam int ELEM_IN_W  = 4;
  localparam int ELEM_OUT_W = 8;
  localparam int MAT_W      = VEC_LEN * VEC_LEN * ELEM_IN_W;
  localparam int XVEC_W     = VEC_LEN * ELEM_IN_W;
  localparam int BVEC_W     = VEC_LEN * ELEM_OUT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/matx_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins; on a tie the requester
// that was not served last wins.
module matx_rr_arb2
  import matx_job_sched_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_last,
  output logic [N_REQ-1:0] o_gnt
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_gnt -- no latch.
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/matx_job_sched.sv
// Job scheduler: arbitrates two requesters, latches operands, sequences the
// external matrix-vector datapath (clear, start, wait) and returns or aborts.
module matx_job_sched
  import matx_job_sched_pkg::*;
#(
  parameter int TIMEOUT = 63,
  parameter int RST_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [MAT_W-1:0]  a_mat0,
  input  logic [MAT_W-1:0]  a_mat1,
  input  logic [XVEC_W-1:0] x_vec0,
  input  logic [XVEC_W-1:0] x_vec1,
  output logic [N_REQ-1:0]  ack,
  output logic [BVEC_W-1:0] b_vec,
  output logic [N_REQ-1:0]  b_valid,
  output logic              err,
  output logic              busy,
  output logic              mp_nrst,
  output logic              mp_start,
  output logic [MAT_W-1:0]  mp_a_mat,
  output logic [XVEC_W-1:0] mp_x_col,
  input  logic [BVEC_W-1:0] mp_b_col,
  input  logic              mp_done
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_prio;     // requester that wins the next tie
  logic               r_gnt_idx;  // requester owning the job in flight
  logic [N_REQ-1:0]   w_gnt;
  logic               w_gnt_idx;
  logic               w_last;

  // The arbiter wants the last-served requester, which is the one without priority.
  assign w_last    = ~r_prio;
  assign w_gnt_idx = w_gnt[1];

  matx_rr_arb2 u_arb (
    .i_req  (req),
    .i_last (w_last),
    .o_gnt  (w_gnt)
  );

  assign busy     = ~rst & (r_state != ST_IDLE);
  assign mp_start = ~rst & (r_state == ST_START);
  assign mp_nrst  = ~rst & (r_state != ST_CLR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_prio    <= 1'b0;
      r_gnt_idx <= 1'b0;
      ack       <= '0;
      b_valid   <= '0;
      err       <= 1'b0;
      b_vec     <= '0;
      mp_a_mat  <= '0;
      mp_x_col  <= '0;
    end else begin
      ack     <= '0;
      b_valid <= '0;
      err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt_idx <= w_gnt_idx;
            ack       <= w_gnt;
            mp_a_mat  <= w_gnt_idx ? a_mat1 : a_mat0;
            mp_x_col  <= w_gnt_idx ? x_vec1 : x_vec0;
            r_cnt     <= '0;
            r_state   <= ST_CLR;
          end
        end
        ST_CLR: begin
          if (r_cnt == CLR_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_START: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion wins over timeout when both land on the last wait cycle.
          if (mp_done) begin
            b_vec   <= mp_b_col;
            b_valid <= r_gnt_idx ? 2'b10 : 2'b01;
            r_prio  <= ~r_gnt_idx;
            r_state <= ST_IDLE;
          end else if (r_cnt == WAIT_LAST) begin
            err     <= 1'b1;
            r_prio  <= ~r_gnt_idx;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matx_job_sched.sv
// Self-checking bench for matx_job_sched: a job-timeline reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_matx_job_sched;
  import matx_job_sched_pkg::*;

  localparam int TIMEOUT = 9;
  localparam int RST_CYC = 3;
  localparam int M_REAL  = 0;
  localparam int M_STUCK = 1;
  localparam int M_HOLD  = 2;
  localparam logic [31:0] HOLD_PAT = 32'hA5C3_0F96;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [63:0] a_mat0 = '0, a_mat1 = '0;
  logic [15:0] x_vec0 = '0, x_vec1 = '0;
  logic [1:0]  ack, b_valid;
  logic [31:0] b_vec, mp_b_col;
  logic        err, busy, mp_nrst, mp_start, mp_done;
  logic [63:0] mp_a_mat;
  logic [15:0] mp_x_col;

  always #5 clk = ~clk;

  matx_job_sched #(.TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_mat0(a_mat0), .a_mat1(a_mat1), .x_vec0(x_vec0), .x_vec1(x_vec1),
    .ack(ack), .b_vec(b_vec), .b_valid(b_valid), .err(err), .busy(busy),
    .mp_nrst(mp_nrst), .mp_start(mp_start), .mp_a_mat(mp_a_mat), .mp_x_col(mp_x_col),
    .mp_b_col(mp_b_col), .mp_done(mp_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // b_i = sum_j a_ij * x_j, kept modulo 256
  function automatic logic [31:0] matvec(input logic [63:0] a, input logic [15:0] x);
    logic [31:0] b;
    int s;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < 4; j++)
        s += int'(a[63-16*i-4*j -: 4]) * int'(x[15-4*j -: 4]);
      b[31-8*i -: 8] = 8'(s);
    end
    return b;
  endfunction

  // External datapath stand-in: real (latency dp_lat), stuck (never done), hold (done always 1)
  int          dp_mode = M_REAL;
  int          dp_lat  = 2;
  int          dp_rem  = 0;
  logic        dp_armed = 1'b0;
  logic        dp_done  = 1'b0;
  logic [31:0] dp_res   = '0;

  always @(negedge clk) begin
    if (!mp_nrst) begin
      dp_armed = 1'b0;
      dp_done  = 1'b0;
    end else if (mp_start) begin
      dp_armed = 1'b1;
      dp_done  = 1'b0;
      dp_rem   = dp_lat;
      dp_res   = matvec(mp_a_mat, mp_x_col);
    end else if (dp_armed) begin
      if (dp_rem > 1) dp_rem--;
      else begin
        dp_armed = 1'b0;
        dp_done  = 1'b1;
      end
    end
  end

  assign mp_done  = (dp_mode == M_HOLD) ? 1'b1 : (dp_mode == M_STUCK) ? 1'b0 : dp_done;
  assign mp_b_col = (dp_mode == M_HOLD) ? HOLD_PAT : dp_res;

  // Reference model: a job is a timeline counted in cycles since its grant.
  // Phase k: 0..RST_CYC-1 clear, RST_CYC start, beyond that waiting.
  logic        m_busy = 1'b0;
  int          m_k    = 0;
  logic        m_prio = 1'b0;
  logic        m_g    = 1'b0;
  logic [1:0]  e_ack = '0, e_bv = '0;
  logic        e_err = 1'b0;
  logic [31:0] e_bvec = '0;
  logic [63:0] e_a = '0;
  logic [15:0] e_x = '0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_k = 0; m_prio = 1'b0;
      e_ack = '0; e_bv = '0; e_err = 1'b0; e_bvec = '0; e_a = '0; e_x = '0;
      chk_en = 1'b1;
    end else begin
      e_ack = '0; e_bv = '0; e_err = 1'b0;
      if (!m_busy) begin
        if (req != 2'b00) begin
          m_g    = (req == 2'b11) ? m_prio : req[1];
          e_ack  = m_g ? 2'b10 : 2'b01;
          e_a    = m_g ? a_mat1 : a_mat0;
          e_x    = m_g ? x_vec1 : x_vec0;
          m_busy = 1'b1;
          m_k    = 0;
        end
      end else begin
        if (m_k > RST_CYC) begin
          if (mp_done) begin
            e_bvec = mp_b_col;
            e_bv   = m_g ? 2'b10 : 2'b01;
            m_busy = 1'b0;
            m_prio = ~m_g;
          end else if (m_k - RST_CYC - 1 == TIMEOUT - 1) begin
            e_err  = 1'b1;
            m_busy = 1'b0;
            m_prio = ~m_g;
          end
        end
        m_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack",      ack,      e_ack);
      check("b_valid",  b_valid,  e_bv);
      check("err",      err,      e_err);
      check("b_vec",    b_vec,    e_bvec);
      check("busy",     busy,     !rst && m_busy);
      check("mp_nrst",  mp_nrst,  !rst && !(m_busy && m_k < RST_CYC));
      check("mp_start", mp_start, !rst && m_busy && m_k == RST_CYC);
      check("mp_a_mat", mp_a_mat, e_a);
      check("mp_x_col", mp_x_col, e_x);
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ack(input int max, output logic [1:0] a);
    a = '0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        a = ack;
        return;
      end
    end
  endtask

  // Follows the current job from this negedge until b_valid or err (bounded).
  task automatic run_job(input int max, output logic [1:0] bv, output logic [31:0] bvec,
                         output logic e, output int nlow, output int nstart, output int nack,
                         output int t_start, output int t_end);
    bv = '0; bvec = '0; e = 1'b0; nlow = 0; nstart = 0; nack = 0; t_start = -1; t_end = -1;
    for (int cyc = 0; cyc < max; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!mp_nrst) nlow++;
      if (mp_start) begin nstart++; t_start = cyc; end
      if (cyc > 0 && ack != 2'b00) nack++;
      if (b_valid != 2'b00 || err) begin
        bv = b_valid; bvec = b_vec; e = err; t_end = cyc;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  a, bv;
    logic [31:0] bvec;
    logic        e;
    int          nlow, nstart, nack, ts, te, cnt;

    // Reset state while rst is high
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_nrst", mp_nrst, 1'b0);
    check("rst_bvec", b_vec, 32'h0);
    check("rst_amat", mp_a_mat, 64'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request, identity-like matrix
    dp_mode = M_REAL; dp_lat = 2;
    a_mat0 = 64'h1000_0100_0010_0001; x_vec0 = 16'h1234;
    req = 2'b01;
    wait_ack(20, a);
    req = 2'b00;
    check("t1_ack", a, 2'b01);
    run_job(100, bv, bvec, e, nlow, nstart, nack, ts, te);
    check("t1_nrst_low_cycles", nlow, RST_CYC);
    check("t1_start_pulses", nstart, 1);
    check("t1_start_cycle", ts, RST_CYC);
    check("t1_done_cycle", te, RST_CYC + 3);
    check("t1_bvalid", bv, 2'b01);
    check("t1_bvec", bvec, 32'h0102_0304);
    check("t1_err", e, 1'b0);

    // Two requesters held together after reset: order 0,1,0,1
    apply_reset();
    a_mat0 = 64'h0123_4567_89AB_CDEF; a_mat1 = 64'h3210_7654_BA98_FEDC;
    x_vec0 = 16'h1234; x_vec1 = 16'h1234;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, a);
      check("t2_ack_order", a, (k % 2 == 0) ? 2'b01 : 2'b10);
      run_job(100, bv, bvec, e, nlow, nstart, nack, ts, te);
      check("t2_bvalid", bv, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("t2_bvec", bvec, (k % 2 == 0) ? 32'h143C_648C : 32'h0A32_5A82);
      check("t2_no_ack_in_flight", nack, 0);
    end
    req = 2'b00;

    // Datapath never finishes: timeout abort, b_vec kept, pointer advances
    dp_mode = M_STUCK;
    req = 2'b01;
    wait_ack(20, a);
    req = 2'b00;
    check("t3_ack", a, 2'b01);
    run_job(200, bv, bvec, e, nlow, nstart, nack, ts, te);
    check("t3_err", e, 1'b1);
    check("t3_no_bvalid", bv, 2'b00);
    check("t3_err_latency", te - ts, TIMEOUT + 1);
    check("t3_busy_low", busy, 1'b0);
    check("t3_bvec_hold", b_vec, 32'h0A32_5A82);
    dp_mode = M_REAL;
    req = 2'b11;
    wait_ack(20, a);
    req = 2'b00;
    check("t3_rr_after_timeout", a, 2'b10);
    run_job(100, bv, bvec, e, nlow, nstart, nack, ts, te);
    check("t3_next_bvalid", bv, 2'b10);

    // Reset pulsed while waiting
    dp_mode = M_STUCK;
    req = 2'b01;
    wait_ack(20, a);
    req = 2'b00;
    repeat (RST_CYC + 3) @(negedge clk);
    check("t4_in_wait_busy", busy, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_busy", busy, 1'b0);
    check("t4_nrst", mp_nrst, 1'b0);
    check("t4_bvalid", b_valid, 2'b00);
    check("t4_err", err, 1'b0);
    check("t4_bvec", b_vec, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    dp_mode = M_REAL;
    cnt = 0;
    repeat (TIMEOUT + 6) begin
      @(negedge clk);
      if (b_valid != 2'b00 || err) cnt++;
    end
    check("t4_no_late_events", cnt, 0);
    a_mat0 = 64'h1111_2222_3333_4444; x_vec0 = 16'h1111;
    req = 2'b01;
    wait_ack(20, a);
    req = 2'b00;
    check("t4_reack", a, 2'b01);
    run_job(100, bv, bvec, e, nlow, nstart, nack, ts, te);
    check("t4_bvalid_after", bv, 2'b01);
    check("t4_bvec_after", bvec, 32'h0408_0C10);

    // Request raised mid-job waits; done held high through clear/start
    dp_lat = 4;
    req = 2'b01;
    wait_ack(20, a);
    req = 2'b00;
    repeat (RST_CYC + 2) @(negedge clk);
    req = 2'b10;
    run_job(100, bv, bvec, e, nlow, nstart, nack, ts, te);
    check("t5_first_bvalid", bv, 2'b01);
    check("t5_no_early_ack", nack, 0);
    dp_mode = M_HOLD;
    wait_ack(2, a);
    req = 2'b00;
    check("t5_ack1_next", a, 2'b10);
    run_job(100, bv, bvec, e, nlow, nstart, nack, ts, te);
    check("t5_hold_bvalid", bv, 2'b10);
    check("t5_hold_bvec", bvec, HOLD_PAT);
    check("t5_hold_latency", te - ts, 2);
    dp_mode = M_REAL;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      a_mat0 = {$urandom, $urandom}; a_mat1 = {$urandom, $urandom};
      x_vec0 = 16'($urandom);        x_vec1 = 16'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        cnt = $urandom_range(0, 9);
        dp_mode = (cnt < 7) ? M_REAL : (cnt < 9) ? M_STUCK : M_HOLD;
        dp_lat  = $urandom_range(1, TIMEOUT + 1);
      end
    end
    @(posedge clk); #1 rst = 1'b0; req = 2'b00;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matx_job_sched.md
MATX_JOB_SCHED -- requirements
Module: matx_job_sched

Interface
REQ-001 Parameter: TIMEOUT, 63, max cycles spent in WAIT before the job is aborted (range 1..255).
REQ-002 Parameter: RST_CYC, 2, cycles mp_nrst is held low before each job (range 1..15).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  2  per-requester job request; bit i = requester i.
REQ-006 a_mat0, a_mat1  in  64 each  4x4 matrix, rows packed {row1,row2,row3,row4}, 4-bit elements, MSB first.
REQ-007 x_vec0, x_vec1  in  16 each  4-element column vector, 4-bit elements, MSB first.
REQ-008 ack  out  2  one-cycle pulse: requester's operands latched.
REQ-009 b_vec  out  32  result {b1,b2,b3,b4}, 8-bit elements.
REQ-010 b_valid  out  2  one-cycle one-hot pulse: b_vec belongs to requester i.
REQ-011 err  out  1  one-cycle pulse: job aborted by timeout.
REQ-012 busy  out  1  high while a job is in flight.
REQ-013 mp_nrst, mp_start  out  1 each  active-low reset and start to the matrix-vector product datapath.
REQ-014 mp_a_mat  out  64, mp_x_col  out  16  latched operands to the datapath.
REQ-015 mp_b_col  in  32, mp_done  in  1  datapath result and completion flag.

Function
REQ-016 FSM states SHALL be IDLE, CLR, START, WAIT; busy=1 in CLR/START/WAIT.
REQ-017 IDLE: on an edge sampling any req bit high, grant one requester g, latch its operands into mp_a_mat/mp_x_col, pulse ack[g] in the next cycle, enter CLR.
REQ-018 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the requester not served last wins; after reset requester 0 has priority.
REQ-019 req sampled only in IDLE; req dropped before ack is not served; req raised while busy is served in the IDLE cycle after completion.
REQ-020 CLR: mp_nrst=0 for exactly RST_CYC cycles, then START.
REQ-021 START: mp_nrst=1, mp_start=1 for exactly one cycle, then WAIT; mp_start=0 in all other states.
REQ-022 mp_done SHALL be ignored outside WAIT.
REQ-023 WAIT: on edge sampling mp_done=1, register b_vec<=mp_b_col, pulse b_valid[g] next cycle, return to IDLE.
REQ-024 WAIT cycle counter starts at 0 on entry; after TIMEOUT cycles without mp_done: pulse err, no b_valid, b_vec unchanged, return to IDLE.
REQ-025 Round-robin pointer SHALL advance after completion or timeout alike.
REQ-026 b_vec holds its value until the next successful completion; elements pass through unmodified (datapath modulo-256 wrap is not corrected).
REQ-027 Back-to-back: minimum spacing between consecutive ack pulses = RST_CYC+3 cycles plus datapath latency.
REQ-028 mp_nrst=1 in IDLE.

Reset
REQ-029 rst SHALL force state IDLE, pointer to requester 0, ack=0, b_valid=0, err=0, busy=0, b_vec=0, mp_start=0, mp_a_mat=0, mp_x_col=0, and mp_nrst=0 while rst is high.
REQ-030 rst in any state SHALL abort the in-flight job with no b_valid and no err; the requester re-requests.

Structure
REQ-031 Shared package SHALL hold the state enum, element widths (4-bit in, 8-bit out), vector length 4 and operand bus widths.
REQ-032 Round-robin grant logic SHALL be a sub-module matx_rr_arb2 (req[1:0], last-served pointer in, one-hot grant out); the datapath is external.

Verification (x=[1,2,3,4], real datapath unless noted)
REQ-033 req0 alone, a_mat0=64'h1000_0100_0010_0001 -> ack[0] pulse, mp_nrst low RST_CYC cycles, one mp_start pulse, b_valid[0] with b_vec={1,2,3,4}.
REQ-034 req0 (64'h0123_4567_89AB_CDEF) and req1 (64'h3210_7654_BA98_FEDC) held high together -> order 0,1,0,1; b_vec {20,60,100,140} then {10,50,90,130}.
REQ-035 Datapath stub with mp_done tied 0 -> err exactly TIMEOUT cycles after WAIT entry, no b_valid, busy low, next req acked.
REQ-036 rst pulsed in WAIT -> reset values next cycle, no b_valid/err, mp_nrst low; later req0 completes normally.
REQ-037 req1 raised during job0 WAIT -> ack[1] only after b_valid[0]; stub holding mp_done=1 through CLR/START causes no early completion.
